core_lsu: RTL

Multi-cycle load/store sequencer placed directly downstream of `core_ex` on its memory port. It turns the execute stage's single-cycle memory request (`mem_req_out`/`mem_rw_out`/`mem_addr_out`/`mem_data_out`) into a req/ack system-bus transaction. It performs the read phase of every load and store, and the write phase of stores, while holding the pipeline through `core_ctrl`. It returns the fetched word to `core_ex` (`mem_data_in`) so that `core_ex` can do its byte/half extraction (loads) and read-modify-write merge (SB/SH).

---
 rtl/core_lsu.sv | 111 +++++++++++
 1 files changed

// File: rtl/core_lsu.sv
// Load/store sequencer: turns core_ex's one-cycle memory request into a req/ack bus read, plus a write for stores.
// Optional bus timeout is enabled with `define CORE_LSU_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module core_lsu #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_req_in,
  input  logic        ex_rw_in,
  input  logic [31:0] ex_addr_in,
  input  logic [31:0] ex_wdata_in,
  output logic [31:0] ex_rdata_out,
  output logic        hold_flag_out,
  output logic        bus_req_out,
  output logic        bus_we_out,
  output logic [31:0] bus_addr_out,
  output logic [31:0] bus_wdata_out,
  input  logic [31:0] bus_rdata_in,
  input  logic        bus_ack_in,
  output logic        err_out
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  localparam int              CNT_W       = (TIMEOUT_CYCLES > 255) ? 16 : 8;
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  state_t state;
  state_t next_state;
  logic   busy;
  logic   timeout;

  assign busy = (state == RD) || (state == WR);

`ifdef CORE_LSU_TIMEOUT_EN
  logic [CNT_W-1:0] wait_cnt;

  // Cleared whenever a bus phase (read or write) is entered, counts unacknowledged cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if ((next_state == RD && state != RD) || (next_state == WR && state != WR)) begin
      wait_cnt <= '0;
    end else if (busy && !bus_ack_in) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign timeout = busy && (wait_cnt == TIMEOUT_VAL);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_VAL;
  assign timeout        = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: every always_comb output gets a default first, otherwise an unassigned path infers a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (ex_req_in) next_state = RD;
      RD: begin
        if (bus_ack_in)   next_state = ex_rw_in ? WR : DONE;
        else if (timeout) next_state = DONE;
      end
      WR: if (bus_ack_in || timeout) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Stall starts combinationally with the request and is released only in DONE.
  always_comb begin
    hold_flag_out = ex_req_in && (state != DONE);
    bus_wdata_out = (state == WR) ? ex_wdata_in : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bus_req_out  <= 1'b0;
      bus_we_out   <= 1'b0;
      bus_addr_out <= 32'h0;
      ex_rdata_out <= 32'h0;
      err_out      <= 1'b0;
    end else begin
      bus_req_out <= (next_state == RD) || (next_state == WR);
      bus_we_out  <= (next_state == WR);
      err_out     <= busy && !bus_ack_in && timeout;

      if (state == IDLE && ex_req_in) begin
        bus_addr_out <= ex_addr_in;
      end

      // A timed-out access returns zero so a load never consumes stale data.
      if (state == RD && bus_ack_in) begin
        ex_rdata_out <= bus_rdata_in;
      end else if (busy && !bus_ack_in && timeout) begin
        ex_rdata_out <= 32'h0;
      end
    end
  end

endmodule
